// File: rtl/vga_mem_arbiter.sv
// Time-slotted arbiter sharing one single-port synchronous pixel RAM between
// the VGA scan-out fetch path (priority, hard deadline) and a host req/ack port.
module vga_mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 8,
    parameter int TICKS_PER_PIXEL = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_strobe,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_overrun,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(TICKS_PER_PIXEL);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(TICKS_PER_PIXEL - 1);
    // Last slot at which a host access still completes before the next strobe.
    localparam logic [SW-1:0] HOST_LAST = SW'(TICKS_PER_PIXEL - 3);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] D_ISSUE = 3'd1;
    localparam logic [2:0] D_WAIT  = 3'd2;
    localparam logic [2:0] H_ISSUE = 3'd3;
    localparam logic [2:0] H_WAIT  = 3'd4;

    logic [2:0]        state;
    logic [SW-1:0]     slot_cnt;
    logic [SW-1:0]     slot;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic              lat_we;
    logic              disp_go;
    logic              host_go;

    assign slot    = pix_strobe ? '0 : slot_cnt;
    assign disp_go = (pix_strobe && disp_req) || pend;
    assign host_go = host_req && !host_ack && (slot <= HOST_LAST);

    // mem_addr / mem_wdata double as the access latch; they are loaded on the
    // grant so the RAM sees the address in the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            slot_cnt     <= SLOT_MAX;
            pend         <= 1'b0;
            pend_addr    <= '0;
            lat_we       <= 1'b0;
            disp_data    <= '0;
            disp_valid   <= 1'b0;
            disp_overrun <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every branch
            // below sees the pre-edge values of state, pend and host_ack.
            slot_cnt     <= (slot == SLOT_MAX) ? SLOT_MAX : slot + 1'b1;
            mem_we       <= 1'b0;
            disp_valid   <= 1'b0;
            disp_overrun <= 1'b0;
            host_ack     <= 1'b0;

            if (pix_strobe && (state != IDLE)) begin
                disp_overrun <= 1'b1;
                if (disp_req) begin
                    pend      <= 1'b1;
                    pend_addr <= disp_addr;
                end
            end

            case (state)
                IDLE: begin
                    if (disp_go) begin
                        mem_addr <= pend ? pend_addr : disp_addr;
                        pend     <= 1'b0;
                        state    <= D_ISSUE;
                    end else if (host_go) begin
                        mem_addr  <= host_addr;
                        mem_wdata <= host_wdata;
                        mem_we    <= host_we;
                        lat_we    <= host_we;
                        state     <= H_ISSUE;
                    end
                end
                D_ISSUE: state <= D_WAIT;
                D_WAIT: begin
                    disp_data  <= mem_rdata;
                    disp_valid <= 1'b1;
                    state      <= IDLE;
                end
                H_ISSUE: state <= H_WAIT;
                H_WAIT: begin
                    if (!lat_we) host_rdata <= mem_rdata;
                    host_ack <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
